// File: rtl/window_scan_controller.sv
// Serpentine window scan sequencer: walks the propagation buffer across a frame,
// handshaking buffer fill, window shift, ready and kernel completion per position.
module window_scan_controller #(
    parameter int COLS        = 8,
    parameter int ROWS        = 8,
    parameter int RDY_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic        abort,
    input  logic        buf_valid,
    input  logic        ready,
    input  logic        kernel_done,
    output logic        buf_req,
    output logic        done,
    output logic [1:0]  next_dir,
    output logic        kernel_start,
    output logic [15:0] win_x,
    output logic [15:0] win_y,
    output logic        busy,
    output logic        frame_done,
    output logic        err
);

    localparam int CW = $clog2(RDY_TIMEOUT + 1);

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ISSUE,
        S_WAIT_RDY,
        S_KSTART,
        S_KWAIT,
        S_FDONE
    } state_t;

    state_t         state_q, state_d;
    logic           dir_left_q, dir_left_d;
    logic [1:0]     pend_q, pend_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [15:0]    x_q, x_d;
    logic [15:0]    y_q, y_d;
    logic           err_q, err_d;

    logic           buf_req_q, buf_req_d;
    logic           done_q, done_d;
    logic [1:0]     next_dir_q, next_dir_d;
    logic           kstart_q, kstart_d;
    logic           busy_q, busy_d;
    logic           fdone_q, fdone_d;

    logic           last_pos;
    logic           at_right_end;
    logic           at_left_end;

    assign at_right_end = (x_q == 16'(COLS - 1));
    assign at_left_end  = (x_q == 16'd0);
    // Row parity decides which end of the last row terminates the frame.
    assign last_pos     = (y_q == 16'(ROWS - 1)) && (y_q[0] ? at_left_end : at_right_end);

    always_comb begin
        state_d    = state_q;
        dir_left_d = dir_left_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        x_d        = x_q;
        y_d        = y_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d        = 16'd0;
                    y_d        = 16'd0;
                    dir_left_d = 1'b0;
                    err_d      = 1'b0;
                    pend_d     = DIR_LEFT;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (buf_valid) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (ready) begin
                    state_d = S_KSTART;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CW'(RDY_TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_KSTART: begin
                state_d = S_KWAIT;
            end
            S_KWAIT: begin
                if (kernel_done) begin
                    if (last_pos) begin
                        state_d = S_FDONE;
                    end else begin
                        state_d = S_REQ;
                        if (!dir_left_q && !at_right_end) begin
                            pend_d = DIR_RIGHT;
                            x_d    = x_q + 16'd1;
                        end else if (dir_left_q && !at_left_end) begin
                            pend_d = DIR_LEFT;
                            x_d    = x_q - 16'd1;
                        end else begin
                            pend_d     = DIR_DOWN;
                            y_d        = y_q + 16'd1;
                            dir_left_d = ~dir_left_q;
                        end
                    end
                end
            end
            S_FDONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything but leaves the scan position and error flag untouched.
        if (abort) begin
            state_d    = S_IDLE;
            dir_left_d = dir_left_q;
            pend_d     = pend_q;
            x_d        = x_q;
            y_d        = y_q;
            err_d      = err_q;
        end
    end

    always_comb begin
        busy_d     = (state_d != S_IDLE);
        buf_req_d  = (state_d == S_REQ);
        done_d     = (state_d == S_ISSUE);
        next_dir_d = (state_d == S_ISSUE) ? pend_d : 2'b00;
        kstart_d   = (state_d == S_KSTART);
        fdone_d    = (state_d == S_FDONE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            dir_left_q <= 1'b0;
            pend_q     <= 2'b00;
            cnt_q      <= '0;
            x_q        <= 16'd0;
            y_q        <= 16'd0;
            err_q      <= 1'b0;
            buf_req_q  <= 1'b0;
            done_q     <= 1'b0;
            next_dir_q <= 2'b00;
            kstart_q   <= 1'b0;
            busy_q     <= 1'b0;
            fdone_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_left_q <= dir_left_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            err_q      <= err_d;
            buf_req_q  <= buf_req_d;
            done_q     <= done_d;
            next_dir_q <= next_dir_d;
            kstart_q   <= kstart_d;
            busy_q     <= busy_d;
            fdone_q    <= fdone_d;
        end
    end

    assign buf_req      = buf_req_q;
    assign done         = done_q;
    assign next_dir     = next_dir_q;
    assign kernel_start = kstart_q;
    assign win_x        = x_q;
    assign win_y        = y_q;
    assign busy         = busy_q;
    assign frame_done   = fdone_q;
    assign err          = err_q;

endmodule

// File: tb/tb_window_scan_controller.sv
// Directed bench: a 3x2 instance for handshake, timeout, stall and abort cases,
// and a 1x3 instance for the single-column case and asynchronous reset.
module tb_window_scan_controller;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A: COLS=3, ROWS=2 ----------------
    logic        start, abort, buf_valid, ready, kernel_done;
    logic        buf_req, done, kernel_start, busy, frame_done, err;
    logic [1:0]  next_dir;
    logic [15:0] win_x, win_y;

    logic auto_bv = 1'b1, auto_rdy = 1'b1, auto_kd = 1'b1, inj = 1'b0;
    logic bv_auto = 1'b0, rdy_auto = 1'b0, kd_auto = 1'b0, st_auto = 1'b0;
    logic bv_man = 1'b0, rdy_man = 1'b0, kd_man = 1'b0, st_man = 1'b0;
    logic done_prev = 1'b0, ks_prev = 1'b0;

    assign buf_valid   = auto_bv  ? bv_auto  : bv_man;
    assign ready       = auto_rdy ? rdy_auto : rdy_man;
    assign kernel_done = auto_kd  ? kd_auto  : kd_man;
    assign start       = st_man | (inj & st_auto);

    window_scan_controller #(.COLS(3), .ROWS(2), .RDY_TIMEOUT(4)) dut_a (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
        .buf_valid(buf_valid), .ready(ready), .kernel_done(kernel_done),
        .buf_req(buf_req), .done(done), .next_dir(next_dir),
        .kernel_start(kernel_start), .win_x(win_x), .win_y(win_y),
        .busy(busy), .frame_done(frame_done), .err(err)
    );

    // ---------------- DUT B: COLS=1, ROWS=3 ----------------
    logic        start_b = 1'b0, abort_b = 1'b0;
    logic        buf_valid_b = 1'b0, ready_b = 1'b0, kernel_done_b = 1'b0;
    logic        buf_req_b, done_b, kernel_start_b, busy_b, frame_done_b, err_b;
    logic [1:0]  next_dir_b;
    logic [15:0] win_x_b, win_y_b;
    logic        done_prev_b = 1'b0, ks_prev_b = 1'b0;

    window_scan_controller #(.COLS(1), .ROWS(3), .RDY_TIMEOUT(4)) dut_b (
        .clk(clk), .n_rst(n_rst), .start(start_b), .abort(abort_b),
        .buf_valid(buf_valid_b), .ready(ready_b), .kernel_done(kernel_done_b),
        .buf_req(buf_req_b), .done(done_b), .next_dir(next_dir_b),
        .kernel_start(kernel_start_b), .win_x(win_x_b), .win_y(win_y_b),
        .busy(busy_b), .frame_done(frame_done_b), .err(err_b)
    );

    // ---------------- logs and counters ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int n_done = 0, n_ks = 0, n_fd = 0;
    int n_done_b = 0, n_fd_b = 0;
    logic [1:0]  dir_log [128];
    logic [15:0] x_log [128];
    logic [15:0] y_log [128];
    logic [1:0]  dir_log_b [128];
    logic [15:0] x_log_b [128];
    logic [15:0] y_log_b [128];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    // Responder A: sample #1 after the edge, answer each request one cycle later.
    always @(posedge clk) begin
        #1;
        if (done) begin
            dir_log[n_done % 128] = next_dir;
            x_log[n_done % 128]   = win_x;
            y_log[n_done % 128]   = win_y;
            $display("A done dir=%0d x=%0d y=%0d", next_dir, win_x, win_y);
            n_done++;
        end
        if (kernel_start) n_ks++;
        if (frame_done) n_fd++;
        bv_auto   = buf_req;
        rdy_auto  = done_prev;
        done_prev = done;
        kd_auto   = ks_prev | (inj & buf_req);
        ks_prev   = kernel_start;
        st_auto   = busy;
    end

    always @(posedge clk) begin
        #1;
        if (done_b) begin
            dir_log_b[n_done_b % 128] = next_dir_b;
            x_log_b[n_done_b % 128]   = win_x_b;
            y_log_b[n_done_b % 128]   = win_y_b;
            $display("B done dir=%0d x=%0d y=%0d", next_dir_b, win_x_b, win_y_b);
            n_done_b++;
        end
        if (frame_done_b) n_fd_b++;
        buf_valid_b   = buf_req_b;
        ready_b       = done_prev_b;
        done_prev_b   = done_b;
        kernel_done_b = ks_prev_b;
        ks_prev_b     = kernel_start_b;
    end

    task automatic wait_fd(input int fd_base);
        int t;
        t = 0;
        while (n_fd == fd_base && t < 300) begin
            cyc(1);
            t++;
        end
    endtask

    task automatic run_frame1(input string tag);
        int base, ks_base, fd_base;
        logic [1:0]  exp_dir [6];
        logic [15:0] exp_x [6];
        logic [15:0] exp_y [6];
        exp_dir = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b01, 2'b01};
        exp_x   = '{16'd0, 16'd1, 16'd2, 16'd2, 16'd1, 16'd0};
        exp_y   = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1};
        base = n_done; ks_base = n_ks; fd_base = n_fd;
        st_man = 1'b1;
        cyc(1);
        st_man = 1'b0;
        wait_fd(fd_base);
        cyc(2);
        chk({tag, "_ndone"}, 64'(n_done - base), 64'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s_dir%0d", tag, i), 64'(dir_log[(base + i) % 128]), 64'(exp_dir[i]));
            chk($sformatf("%s_x%0d", tag, i), 64'(x_log[(base + i) % 128]), 64'(exp_x[i]));
            chk($sformatf("%s_y%0d", tag, i), 64'(y_log[(base + i) % 128]), 64'(exp_y[i]));
        end
        chk({tag, "_nks"}, 64'(n_ks - ks_base), 64'd6);
        chk({tag, "_nfd"}, 64'(n_fd - fd_base), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_final_xy"}, {win_x, win_y}, {16'd0, 16'd1});
        chk({tag, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        int t;
        int fd_base;
        int b_base;
        logic [1:0]  exp_dir_b [3];
        abort = 1'b0;

        // Reset values
        cyc(2);
        chk("rst_a_outputs", {buf_req, done, next_dir, kernel_start, win_x, win_y, busy, frame_done, err}, 64'd0);
        chk("rst_b_outputs", {buf_req_b, done_b, next_dir_b, kernel_start_b, win_x_b, win_y_b, busy_b, frame_done_b, err_b}, 64'd0);
        n_rst = 1'b1;
        cyc(2);
        chk("idle_nextdir", 64'(next_dir), 64'd0);

        // Nominal 3x2 frame
        run_frame1("s1");

        // Same frame with spurious start while busy and kernel_done during REQ
        inj = 1'b1;
        run_frame1("s5");
        inj = 1'b0;
        cyc(2);

        // Ready timeout
        auto_rdy = 1'b0;
        rdy_man  = 1'b0;
        st_man = 1'b1;
        cyc(1);
        st_man = 1'b0;
        t = 0;
        while (!done && t < 50) begin
            cyc(1);
            t++;
        end
        chk("s2_done_seen", 64'(done), 64'd1);
        chk("s2_dir_initial", 64'(next_dir), 64'd1);
        cyc(4);
        chk("s2_err_early", {err, busy}, {1'b0, 1'b1});
        cyc(1);
        chk("s2_err_set", {err, busy}, {1'b1, 1'b0});
        cyc(3);
        chk("s2_err_sticky", 64'(err), 64'd1);
        auto_rdy = 1'b1;
        fd_base = n_fd;
        st_man = 1'b1;
        cyc(1);
        st_man = 1'b0;
        chk("s2_err_cleared", {err, busy}, {1'b0, 1'b1});
        wait_fd(fd_base);
        cyc(2);
        chk("s2_frame_after", 64'(n_fd - fd_base), 64'd1);

        // buf_valid stall
        auto_bv = 1'b0;
        bv_man  = 1'b0;
        st_man = 1'b1;
        cyc(1);
        st_man = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("s3_hold%0d", i), {buf_req, done}, 2'b10);
            cyc(1);
        end
        bv_man = 1'b1;
        cyc(1);
        bv_man = 1'b0;
        chk("s3_done_fire", {buf_req, done, next_dir}, 4'b0101);
        auto_bv = 1'b1;
        fd_base = n_fd;
        wait_fd(fd_base);
        cyc(2);
        chk("s3_frame_after", 64'(n_fd - fd_base), 64'd1);

        // Abort while waiting for the kernel at window (1,0)
        fd_base = n_fd;
        st_man = 1'b1;
        cyc(1);
        st_man = 1'b0;
        t = 0;
        while (!(kernel_start && win_x == 16'd1) && t < 100) begin
            cyc(1);
            t++;
        end
        chk("s4_kstart_x1", {kernel_start, win_x}, {1'b1, 16'd1});
        auto_kd = 1'b0;
        kd_man  = 1'b0;
        cyc(1);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("s4_abort_idle", {busy, frame_done, kernel_start, buf_req}, 4'b0000);
        chk("s4_abort_xy", {win_x, win_y}, {16'd1, 16'd0});
        kd_man = 1'b1;
        cyc(1);
        kd_man = 1'b0;
        cyc(2);
        chk("s4_kd_ignored", {busy, buf_req, done}, 3'b000);
        chk("s4_x_holds", 64'(win_x), 64'd1);
        chk("s4_no_fd", 64'(n_fd - fd_base), 64'd0);
        auto_kd = 1'b1;

        // Single column, three rows
        exp_dir_b = '{2'b01, 2'b10, 2'b10};
        b_base = n_done_b;
        start_b = 1'b1;
        cyc(1);
        start_b = 1'b0;
        t = 0;
        while (n_fd_b == 0 && t < 300) begin
            cyc(1);
            t++;
        end
        cyc(2);
        chk("s6_ndone", 64'(n_done_b - b_base), 64'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("s6_dir%0d", i), 64'(dir_log_b[(b_base + i) % 128]), 64'(exp_dir_b[i]));
            chk($sformatf("s6_xy%0d", i), {x_log_b[(b_base + i) % 128], y_log_b[(b_base + i) % 128]},
                {16'd0, 16'(i)});
        end
        chk("s6_nfd", 64'(n_fd_b), 64'd1);
        chk("s6_busy", 64'(busy_b), 64'd0);

        // Asynchronous reset mid-frame
        b_base = n_done_b;
        start_b = 1'b1;
        cyc(1);
        start_b = 1'b0;
        t = 0;
        while (n_done_b - b_base < 2 && t < 100) begin
            cyc(1);
            t++;
        end
        chk("s6_midframe", {busy_b, win_y_b}, {1'b1, 16'd1});
        n_rst = 1'b0;
        #1;
        chk("s6_async_rst_b", {buf_req_b, done_b, next_dir_b, kernel_start_b, win_x_b, win_y_b, busy_b, frame_done_b, err_b}, 64'd0);
        chk("s6_async_rst_a", {buf_req, done, next_dir, kernel_start, win_x, win_y, busy, frame_done, err}, 64'd0);
        cyc(2);
        n_rst = 1'b1;
        cyc(2);
        chk("s6_post_rst_idle", {busy_b, frame_done_b}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
